ahb_resp_mux: RTL and testbench
===============================

# ahb_resp_mux

Parametrised AHB-Lite slave-to-master response multiplexer with an integrated default slave. Sits between the address decoder and the single AHB master. It registers the decoder selection at each address-phase acceptance and routes the selected slave's data-phase response (ready, resp, rdata) back to the master. Unmapped selections get a protocol-correct two-cycle ERROR from the built-in default slave.

## Interface
Parameters:
- `SLAVES`, 4, number of attached slaves (1..16).
- `DATA_WIDTH`, 32, read data width (32 or 64).
- `SEL_W`, $clog2(SLAVES)+1, decoder select width. Values >= `SLAVES` mean unmapped.
- `ERR_CNT_W`, 8, width of the saturating unmapped-access counter.

Ports:
- `clk`  in  1  bus clock.
- `rstn`  in  1  reset; asynchronous, active-low.
- `decoder_sel`  in  SEL_W  address-phase slave index from the decoder.
- `htrans`  in  2  master HTRANS, address phase.
- `slaves_ready`  in  SLAVES  per-slave HREADYOUT.
- `slaves_resp`  in  SLAVES  per-slave HRESP (1 = ERROR).
- `slaves_rdata`  in  SLAVES x DATA_WIDTH  per-slave HRDATA, unpacked array.
- `slaves_sel`  out  SLAVES  one-hot HSEL, address phase, combinational.
- `master_ready`  out  1  HREADY to the master, also broadcast to all slaves.
- `master_resp`  out  1  HRESP to the master.
- `master_rdata`  out  DATA_WIDTH  HRDATA to the master.
- `err_count`  out  ERR_CNT_W  count of ERROR responses issued by the default slave; saturates at its maximum.

## Operation
- Address-phase decode:
  - `slaves_sel[i]` = (`decoder_sel` == i) and (`htrans[1]`). Only NONSEQ/SEQ assert HSEL.
  - An unmapped select asserts no HSEL bit.
- Data-phase select register `dsel` (SEL_W bits) plus `dactive` flag.
  - Both load when `master_ready`=1: `dsel`<=`decoder_sel`, `dactive`<=`htrans[1]`.
  - They hold otherwise.
- Output mux:
  - If `dactive`=1 and `dsel` < SLAVES: outputs come from slave `dsel`.
  - Otherwise: outputs come from the default slave.
- Default slave FSM (sub-module), states:
  - IDLE: ready=1, resp=0.
  - ERR1: ready=0, resp=1.
  - ERR2: ready=1, resp=1.
- Default slave transitions:
  - IDLE -> ERR1 when `master_ready`=1, `htrans[1]`=1 and `decoder_sel` >= SLAVES.
  - ERR1 -> ERR2 unconditionally.
  - ERR2 -> ERR1 if a new unmapped NONSEQ/SEQ is accepted that cycle, otherwise -> IDLE.
- Default slave rdata is always 0.
- `err_count` increments by 1 on each ERR2 cycle and saturates at 2^ERR_CNT_W-1.
- IDLE/BUSY transfers to any select: zero-wait OKAY.
  - For a mapped slave this comes from the slave's own response (the slave must give OKAY per AHB).
  - For unmapped, from the default slave IDLE state.

## Timing
- Reset values (async assert, sync-free release):
  - `dsel`=SLAVES, `dactive`=0, FSM=IDLE, `err_count`=0.
  - Hence `master_ready`=1, `master_resp`=0, `master_rdata`=0.
- Response path is combinational from `slaves_*` to `master_*`: zero added latency.
- Select latency: one cycle. The address phase accepted at edge N selects the response during cycle N..next-accept.
- Wait states: while the selected slave holds ready=0, `dsel` holds and a new `decoder_sel` is ignored.
- Back-to-back transfers: mapped -> unmapped -> mapped gives mapped OKAY, ERR1, ERR2, mapped OKAY with no bubble beyond the ERROR's own wait cycle.
- Mapped-slave two-cycle ERROR: passed through unmodified; not counted in `err_count`.
- Reset mid-transfer: all state returns to reset values immediately. Any in-flight response is dropped.
- SLAVES=1: `dsel` compares against 0 only. Select values 1 and up are unmapped.

## Structure
- Shared package `ahb_pkg`:
  - `htrans_t` enum (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
  - `HRESP_OKAY`/`HRESP_ERROR` constants.
  - Default parameter values.
- Sub-module `ahb_default_slave`: 3-state FSM plus the saturating counter.
- Top level holds only the decode, `dsel` register and mux.

## Test plan
- Reset: assert `rstn`=0 mid-ERR1 -> immediately `master_ready`=1, `master_resp`=0, `master_rdata`=0, `err_count`=0.
- Mapped read: sel=2, NONSEQ, slave2 returns rdata=0xA5A5_1234 after 2 wait cycles -> `slaves_sel`=4'b0100 in the address phase; `master_ready` low 2 cycles, then the data appears with resp=0.
- Unmapped access: sel=4 (SLAVES=4), NONSEQ -> next cycle ready=0/resp=1, then ready=1/resp=1; `err_count`=1; no HSEL bit set.
- Pipelined mix: NONSEQ sel0, NONSEQ sel5, SEQ sel1 back-to-back -> responses OKAY, ERR1, ERR2, OKAY in order; `dsel` holds during ERR1.
- IDLE to unmapped: sel=7, IDLE -> zero-wait OKAY, `err_count` unchanged, `slaves_sel`=0.
- Saturation: ERR_CNT_W=2, 5 unmapped NONSEQs -> `err_count` reads 3 and stays at 3.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer types, response codes, and default
// parameter values used by the response multiplexer and its default slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int DEF_SLAVES     = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ERR_CNT_W  = 8;

  // Default-slave states; ERR1 is the wait cycle of the two-cycle ERROR.
  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

endpackage

// File: rtl/ahb_resp_mux_if.sv
// Bus bundle between decoder/master and the slaves, as seen by the response
// multiplexer (slave modport) and by whatever drives it (master modport).
interface ahb_resp_mux_if import ahb_pkg::*; #(
  parameter int SLAVES     = DEF_SLAVES,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SEL_W      = $clog2(SLAVES) + 1
);
  // A transfer is accepted on a rising edge where master_ready=1 and
  // htrans is NONSEQ/SEQ; master_ready=0 stalls both the address phase
  // (decoder_sel/htrans must hold) and the data phase of the current transfer.
  logic [SEL_W-1:0]      decoder_sel;
  logic [1:0]            htrans;
  logic [SLAVES-1:0]     slaves_ready;
  logic [SLAVES-1:0]     slaves_resp;
  logic [DATA_WIDTH-1:0] slaves_rdata [SLAVES];
  logic [SLAVES-1:0]     slaves_sel;
  logic                  master_ready;
  logic                  master_resp;
  logic [DATA_WIDTH-1:0] master_rdata;

  modport slave (
    input  decoder_sel, htrans, slaves_ready, slaves_resp, slaves_rdata,
    output slaves_sel, master_ready, master_resp, master_rdata
  );

  modport master (
    output decoder_sel, htrans, slaves_ready, slaves_resp, slaves_rdata,
    input  slaves_sel, master_ready, master_resp, master_rdata
  );

endinterface

// File: rtl/ahb_default_slave.sv
// Built-in default slave: answers unmapped NONSEQ/SEQ transfers with a
// two-cycle ERROR and counts each ERROR issued, saturating at the maximum.
module ahb_default_slave import ahb_pkg::*; #(
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 accept_unmapped_i,
  output logic                 ready_o,
  output logic                 resp_o,
  output logic [ERR_CNT_W-1:0] err_count_o,
  output ds_state_t            state_o
);

  ds_state_t            state_q, state_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= DS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = DS_IDLE;
    ready_o = 1'b1;
    resp_o  = HRESP_OKAY;
    cnt_d   = cnt_q;
    case (state_q)
      DS_IDLE: begin
        if (accept_unmapped_i) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        ready_o = 1'b0;
        resp_o  = HRESP_ERROR;
        state_d = DS_ERR2;
      end
      DS_ERR2: begin
        resp_o = HRESP_ERROR;
        // The final ERROR cycle may overlap the next unmapped address phase.
        if (accept_unmapped_i) state_d = DS_ERR1;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
      default: state_d = DS_IDLE;
    endcase
  end

  assign err_count_o = cnt_q;
  assign state_o     = state_q;

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-Lite response multiplexer: address-phase HSEL decode, registered
// data-phase select, and combinational routing of the selected response.
module ahb_resp_mux import ahb_pkg::*; #(
  parameter int SLAVES     = DEF_SLAVES,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SEL_W      = $clog2(SLAVES) + 1,
  parameter int ERR_CNT_W  = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  ahb_resp_mux_if.slave        bus,
  output logic [ERR_CNT_W-1:0] err_count,
  output ds_state_t            dbg_state_o
);

  localparam logic [SEL_W-1:0] SEL_UNMAPPED = SEL_W'(SLAVES);

  logic              trans_active;
  logic              sel_mapped;
  logic              accept_unmapped;
  logic [SLAVES-1:0] hsel;
  logic [SEL_W-1:0]  dsel_q, dsel_d;
  logic              dactive_q, dactive_d;
  logic              ds_ready, ds_resp;

  assign trans_active = (htrans_t'(bus.htrans) == HTRANS_NONSEQ) ||
                        (htrans_t'(bus.htrans) == HTRANS_SEQ);
  assign sel_mapped   = (bus.decoder_sel < SEL_UNMAPPED);

  always_comb begin
    hsel = '0;
    for (int i = 0; i < SLAVES; i++) begin
      hsel[i] = trans_active && (bus.decoder_sel == SEL_W'(i));
    end
  end
  assign bus.slaves_sel = hsel;

  // Data-phase select only advances when the current data phase completes.
  always_comb begin
    dsel_d    = dsel_q;
    dactive_d = dactive_q;
    if (bus.master_ready) begin
      dsel_d    = bus.decoder_sel;
      dactive_d = trans_active;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dsel_q    <= SEL_UNMAPPED;
      dactive_q <= 1'b0;
    end else begin
      dsel_q    <= dsel_d;
      dactive_q <= dactive_d;
    end
  end

  assign accept_unmapped = bus.master_ready && trans_active && !sel_mapped;

  ahb_default_slave #(
    .ERR_CNT_W (ERR_CNT_W)
  ) u_default_slave (
    .clk               (clk),
    .rstn              (rstn),
    .accept_unmapped_i (accept_unmapped),
    .ready_o           (ds_ready),
    .resp_o            (ds_resp),
    .err_count_o       (err_count),
    .state_o           (dbg_state_o)
  );

  // Unmapped or idle data phases fall through to the default slave (rdata 0).
  always_comb begin
    bus.master_ready = ds_ready;
    bus.master_resp  = ds_resp;
    bus.master_rdata = '0;
    for (int i = 0; i < SLAVES; i++) begin
      if (dactive_q && (dsel_q == SEL_W'(i))) begin
        bus.master_ready = bus.slaves_ready[i];
        bus.master_resp  = bus.slaves_resp[i];
        bus.master_rdata = bus.slaves_rdata[i];
      end
    end
  end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Bench for ahb_resp_mux: directed vector table, reset and saturation
// sequences, then random traffic against a transfer-level reference model.
module tb_ahb_resp_mux;
  import ahb_pkg::*;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int SW = 3;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ahb_resp_mux_if #(.SLAVES(NS), .DATA_WIDTH(DW), .SEL_W(SW)) bus ();
  logic [CW-1:0] err_count;
  ds_state_t     dbg_state;

  ahb_resp_mux #(
    .SLAVES(NS), .DATA_WIDTH(DW), .SEL_W(SW), .ERR_CNT_W(CW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus.slave),
    .err_count   (err_count),
    .dbg_state_o (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // Stimulus copies kept by the bench.
  logic [SW-1:0] sel_v;
  logic [1:0]    tr_v;
  logic [NS-1:0] rdy_v;
  logic [NS-1:0] rsp_v;
  logic [DW-1:0] dat_v [NS];

  // Reference model: 0 = no data phase, 1 = mapped slave m_slv,
  // 2 = first ERROR cycle, 3 = second ERROR cycle.
  int m_kind = 0;
  int m_slv  = 0;
  int m_cnt  = 0;

  typedef struct {
    logic [SW-1:0] sel;
    logic [1:0]    trans;
    logic [NS-1:0] rdy;
    logic [NS-1:0] rsp;
    logic [NS-1:0] e_hsel;
    logic          e_rdy;
    logic          e_rsp;
    logic [DW-1:0] e_data;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [SW-1:0] sel, input logic [1:0] tr,
                       input logic [NS-1:0] rdy, input logic [NS-1:0] rsp);
    @(negedge clk);
    sel_v = sel; tr_v = tr; rdy_v = rdy; rsp_v = rsp;
    bus.decoder_sel  = sel;
    bus.htrans       = tr;
    bus.slaves_ready = rdy;
    bus.slaves_resp  = rsp;
    for (int i = 0; i < NS; i++) bus.slaves_rdata[i] = dat_v[i];
    #1;
  endtask

  task automatic model_reset();
    m_kind = 0; m_slv = 0; m_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    bus.htrans = HTRANS_IDLE;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  // Compare this cycle's outputs with the model, then advance the model
  // across the coming rising edge.
  task automatic model_cycle(input string tag);
    logic          e_rdy, e_rsp;
    logic [DW-1:0] e_dat;
    logic [NS-1:0] e_hsel;
    e_rdy = 1'b1; e_rsp = 1'b0; e_dat = '0;
    if (m_kind == 1) begin
      e_rdy = rdy_v[m_slv]; e_rsp = rsp_v[m_slv]; e_dat = dat_v[m_slv];
    end else if (m_kind == 2) begin
      e_rdy = 1'b0; e_rsp = 1'b1;
    end else if (m_kind == 3) begin
      e_rsp = 1'b1;
    end
    e_hsel = (tr_v[1] && sel_v < NS) ? (NS'(1) << sel_v) : '0;
    chk({tag, " hsel"},  64'(bus.slaves_sel),   64'(e_hsel));
    chk({tag, " ready"}, 64'(bus.master_ready), 64'(e_rdy));
    chk({tag, " resp"},  64'(bus.master_resp),  64'(e_rsp));
    chk({tag, " rdata"}, 64'(bus.master_rdata), 64'(e_dat));
    chk({tag, " count"}, 64'(err_count),        64'(m_cnt));
    if (m_kind == 3) m_cnt = (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
    if (m_kind == 2) m_kind = 3;
    else if (e_rdy) begin
      if (tr_v[1]) begin
        if (sel_v < NS) begin m_kind = 1; m_slv = int'(sel_v); end
        else m_kind = 2;
      end else m_kind = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < NS; i++) dat_v[i] = 32'hA5A5_1232 + DW'(i);
    bus.decoder_sel  = '0;
    bus.htrans       = HTRANS_IDLE;
    bus.slaves_ready = '1;
    bus.slaves_resp  = '0;
    for (int i = 0; i < NS; i++) bus.slaves_rdata[i] = dat_v[i];

    //          sel   tr    rdy    rsp    hsel     rdy   rsp   rdata          cnt
    vt[0]  = '{3'd2, 2'd2, 4'hF, 4'h0, 4'b0100, 1'b1, 1'b0, 32'h0,         2'd0};
    vt[1]  = '{3'd1, 2'd2, 4'hB, 4'h0, 4'b0010, 1'b0, 1'b0, 32'hA5A5_1234, 2'd0};
    vt[2]  = '{3'd1, 2'd2, 4'hB, 4'h0, 4'b0010, 1'b0, 1'b0, 32'hA5A5_1234, 2'd0};
    vt[3]  = '{3'd0, 2'd2, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b0, 32'hA5A5_1234, 2'd0};
    vt[4]  = '{3'd5, 2'd2, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, 32'hA5A5_1232, 2'd0};
    vt[5]  = '{3'd1, 2'd3, 4'hF, 4'h0, 4'b0010, 1'b0, 1'b1, 32'h0,         2'd0};
    vt[6]  = '{3'd1, 2'd3, 4'hF, 4'h0, 4'b0010, 1'b1, 1'b1, 32'h0,         2'd0};
    vt[7]  = '{3'd7, 2'd0, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, 32'hA5A5_1233, 2'd1};
    vt[8]  = '{3'd7, 2'd0, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, 32'h0,         2'd1};
    vt[9]  = '{3'd3, 2'd2, 4'hF, 4'h0, 4'b1000, 1'b1, 1'b0, 32'h0,         2'd1};
    vt[10] = '{3'd0, 2'd1, 4'h7, 4'h8, 4'b0000, 1'b0, 1'b1, 32'hA5A5_1235, 2'd1};
    vt[11] = '{3'd0, 2'd1, 4'hF, 4'h8, 4'b0000, 1'b1, 1'b1, 32'hA5A5_1235, 2'd1};
    vt[12] = '{3'd4, 2'd2, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, 32'h0,         2'd1};
    vt[13] = '{3'd0, 2'd0, 4'hF, 4'h0, 4'b0000, 1'b0, 1'b1, 32'h0,         2'd1};
    vt[14] = '{3'd0, 2'd0, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b1, 32'h0,         2'd1};
    vt[15] = '{3'd0, 2'd0, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, 32'h0,         2'd2};

    // Reset values while rstn is held low.
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset ready", 64'(bus.master_ready), 64'd1);
    chk("reset resp",  64'(bus.master_resp),  64'd0);
    chk("reset rdata", 64'(bus.master_rdata), 64'd0);
    chk("reset count", 64'(err_count),        64'd0);
    chk("reset hsel",  64'(bus.slaves_sel),   64'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int v = 0; v < 16; v++) begin
      drive(vt[v].sel, vt[v].trans, vt[v].rdy, vt[v].rsp);
      chk($sformatf("vec%0d hsel", v),  64'(bus.slaves_sel),   64'(vt[v].e_hsel));
      chk($sformatf("vec%0d ready", v), 64'(bus.master_ready), 64'(vt[v].e_rdy));
      chk($sformatf("vec%0d resp", v),  64'(bus.master_resp),  64'(vt[v].e_rsp));
      chk($sformatf("vec%0d rdata", v), 64'(bus.master_rdata), 64'(vt[v].e_data));
      chk($sformatf("vec%0d count", v), 64'(err_count),        64'(vt[v].e_cnt));
    end

    // Reset asserted in the middle of an ERR1 wait cycle.
    m_kind = 0; m_cnt = 2;
    drive(3'd4, 2'd2, 4'hF, 4'h0);
    model_cycle("prerst accept");
    drive(3'd0, 2'd0, 4'hF, 4'h0);
    model_cycle("prerst err1");
    rstn = 1'b0;
    #1;
    chk("midrst ready", 64'(bus.master_ready), 64'd1);
    chk("midrst resp",  64'(bus.master_resp),  64'd0);
    chk("midrst rdata", 64'(bus.master_rdata), 64'd0);
    chk("midrst count", 64'(err_count),        64'd0);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();

    // Five back-to-back unmapped NONSEQs saturate the 2-bit counter.
    for (int c = 0; c < 9; c++) begin
      drive(3'(4 + (c % 4)), 2'd2, 4'hF, 4'h0);
      model_cycle($sformatf("sat%0d", c));
    end
    for (int c = 9; c < 12; c++) begin
      drive(3'd6, 2'd0, 4'hF, 4'h0);
      model_cycle($sformatf("sat%0d", c));
    end
    chk("sat count", 64'(err_count), 64'd3);
    repeat (3) drive(3'd5, 2'd0, 4'hF, 4'h0);
    chk("sat hold",  64'(err_count), 64'd3);

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [NS-1:0] rdy, rsp;
      for (int i = 0; i < NS; i++) begin
        rdy[i]   = ($urandom_range(0, 3) != 0);
        rsp[i]   = ($urandom_range(0, 5) == 0);
        dat_v[i] = $urandom;
      end
      drive(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), rdy, rsp);
      model_cycle($sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
